// File: rtl/pipelined_adder_if.sv
// Valid/ready operand and result channels of the sliced pipelined adder.
// The master side drives operands and result-ready; the slave side is the adder.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// Add/subtract unit split into WIDTH/SLICE carry-registered stages with a
// valid/ready handshake; a stalled output freezes the whole pipeline in place.
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    pipelined_adder_if.slave   bus
);
    localparam int STAGES = (SLICE >= 1) ? WIDTH / SLICE : 1;

    if (SLICE < 1 || WIDTH < SLICE || ((SLICE >= 1) ? (WIDTH % SLICE) : 1) != 0) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be a positive multiple of SLICE");
    end

    logic out_valid;
    logic stall;

    assign stall        = out_valid && !bus.out_ready;
    assign bus.in_ready = rst_n && !stall;

    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        // Stage gi only carries the operand bits it and later stages still need,
        // and the sum bits already completed below it.
        localparam int LO  = gi * SLICE;
        localparam int REM = WIDTH - LO;

        logic [REM-1:0]        a_in;
        logic [REM-1:0]        bp_in;
        logic                  carry_in;
        logic                  valid_in;
        logic [SLICE:0]        slice_res;
        logic [LO+SLICE-1:0]   sum_next;
        logic [LO+SLICE-1:0]   sum_reg;
        logic                  carry_reg;
        logic                  valid_reg;

        if (gi == 0) begin : g_head
            assign a_in     = bus.a;
            assign bp_in    = bus.sub ? ~bus.b : bus.b;
            assign carry_in = bus.cin;
            assign valid_in = bus.in_valid;
            assign sum_next = slice_res[SLICE-1:0];
        end else begin : g_body
            assign a_in     = g_stage[gi-1].g_fwd.a_reg;
            assign bp_in    = g_stage[gi-1].g_fwd.bp_reg;
            assign carry_in = g_stage[gi-1].carry_reg;
            assign valid_in = g_stage[gi-1].valid_reg;
            assign sum_next = {slice_res[SLICE-1:0], g_stage[gi-1].sum_reg};
        end

        assign slice_res = {1'b0, a_in[SLICE-1:0]}
                         + {1'b0, bp_in[SLICE-1:0]}
                         + {{SLICE{1'b0}}, carry_in};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg <= 1'b0;
                carry_reg <= 1'b0;
                sum_reg   <= '0;
            end else if (!stall) begin
                valid_reg <= valid_in;
                carry_reg <= slice_res[SLICE];
                sum_reg   <= sum_next;
            end
        end

        if (gi < STAGES - 1) begin : g_fwd
            logic [REM-SLICE-1:0] a_reg;
            logic [REM-SLICE-1:0] bp_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_reg  <= '0;
                    bp_reg <= '0;
                end else if (!stall) begin
                    a_reg  <= a_in[REM-1:SLICE];
                    bp_reg <= bp_in[REM-1:SLICE];
                end
            end
        end else begin : g_last
            // The top slice holds both operand sign bits, so overflow is
            // resolved here and registered alongside the final sum slice.
            logic ovf_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_reg <= 1'b0;
                end else if (!stall) begin
                    ovf_reg <= (a_in[SLICE-1] == bp_in[SLICE-1])
                            && (slice_res[SLICE-1] != a_in[SLICE-1]);
                end
            end
        end
    end

    assign out_valid     = g_stage[STAGES-1].valid_reg;
    assign bus.out_valid = out_valid;
    assign bus.sum       = g_stage[STAGES-1].sum_reg;
    assign bus.cout      = g_stage[STAGES-1].carry_reg;
    assign bus.ovf       = g_stage[STAGES-1].g_last.ovf_reg;
endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and rst_n.
REQ-002 Parameter WIDTH, default 16, operand and sum width in bits.
REQ-003 Parameter SLICE, default 4, bits summed per pipeline stage; STAGES = WIDTH/SLICE.
REQ-004 Elaboration SHALL fail if WIDTH % SLICE != 0, SLICE < 1 or WIDTH < SLICE.
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  operands on a/b/cin/sub are valid.
REQ-008 in_ready  output  1  block accepts operands this cycle.
REQ-009 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-010 b  input  WIDTH  operand B.
REQ-011 cin  input  1  carry-in into bit 0.
REQ-012 sub  input  1  0 = add, 1 = subtract.
REQ-013 out_valid  output  1  sum/cout/ovf hold a valid result.
REQ-014 out_ready  input  1  downstream accepts the result this cycle.
REQ-015 sum  output  WIDTH  result.
REQ-016 cout  output  1  carry out of bit WIDTH-1.
REQ-017 ovf  output  1  signed two's-complement overflow.

Function
REQ-018 Arithmetic: B' = sub ? ~b : b; {cout, sum} = a + B' + cin, exact modulo 2^(WIDTH+1).
- Plain subtract: sub=1, cin=1.
- Borrow chaining: sub=1, cin=0.
REQ-019 ovf SHALL be 1 iff a[WIDTH-1] == B'[WIDTH-1] and sum[WIDTH-1] != a[WIDTH-1].
REQ-020 Input transfer occurs on a rising edge where in_valid && in_ready; output transfer occurs where out_valid && out_ready.
REQ-021 Stage k (0..STAGES-1) SHALL add slice k of a and B' with the carry registered by stage k-1. Stage 0 uses cin.
- Operand slices for higher stages are delayed.
- Completed lower sum slices are carried forward, so each transaction stays aligned.
REQ-022 Each stage SHALL carry a valid bit. With no stall, a result SHALL appear on out_valid exactly STAGES cycles after the accepting edge.
REQ-023 Stall: stall = out_valid && !out_ready.
- in_ready = rst_n && !stall, combinational.
- While stall = 1, every stage register (data, carry and valid) SHALL hold.
- Bubbles SHALL NOT be squeezed out.
REQ-024 When not stalled, the pipeline SHALL advance every cycle. A bubble enters stage 0 when in_valid = 0.
REQ-025 Throughput SHALL be one transaction per cycle while out_ready = 1.
REQ-026 Results SHALL leave in acceptance order, with no loss or duplication.
REQ-027 sum/cout/ovf SHALL remain stable while out_valid && !out_ready.
REQ-028 Inputs presented while in_ready = 0 SHALL be ignored.
REQ-029 Simultaneous output transfer and input acceptance in the same cycle SHALL be supported.
REQ-030 Operand changes between transfers SHALL NOT affect in-flight results.
REQ-031 STAGES = 1 SHALL degenerate to a single registered adder with latency 1.

Reset
REQ-032 While rst_n = 0, the following SHALL be forced to 0 asynchronously: all stage valid bits, out_valid, sum, cout, ovf, in_ready and all carry registers.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight transactions. After release, no stale result SHALL ever appear.
REQ-034 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification (WIDTH=16, SLICE=4, STAGES=4)
REQ-035 Carry ripple across all slices: a=0xFFFF, b=0x0001, cin=0, sub=0 -> 4 cycles later out_valid=1, sum=0x0000, cout=1, ovf=0.
REQ-036 Subtract: a=0x0005, b=0x0007, cin=1, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
- Also a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
REQ-037 Overflow: a=0x7FFF, b=0x0001, add -> sum=0x8000, ovf=1, cout=0.
- Also a=0x8000, b=0x0001, cin=1, sub=1 -> sum=0x7FFF, ovf=1.
REQ-038 Backpressure: 6 back-to-back inputs, with out_ready=0 for 3 cycles mid-stream.
- in_ready=0 exactly while out_valid && !out_ready.
- Outputs are held stable while stalled.
- All 6 results are correct and in order.
REQ-039 Reset mid-flight: 3 transactions accepted, rst_n pulsed low for 1 cycle.
- out_valid=0 and sum=0 immediately.
- No result appears in the following 8 cycles without new input.
- A new input returns its correct result 4 cycles after acceptance.
REQ-040 Random: 10k random operand/sub/cin streams with random in_valid/out_ready at WIDTH=16/SLICE=4 and WIDTH=8/SLICE=8, checked against a reference model for sum, cout, ovf and ordering.
